// File: rtl/gpr_file_sb.sv
// gpr_file_sb -- parametrised general-purpose register file with a
// per-register pending-write scoreboard for the ID-stage hazard unit.
//
// Parameters:
//   DATA_W   register width in bits
//   ADDR_W   address width; depth = 2**ADDR_W
//   NUM_RD   number of read ports (1..4)
//   ZERO_REG 1 = register 0 reads as zero and ignores writes
//   PEND_W   pending-counter width; max outstanding writes = 2**PEND_W-1
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   we/waddr/wdata    writeback port (WB stage)
//   rd_en/rd_addr     per-port read enable and packed read addresses
//   rd_data/rd_busy   packed read data and per-port scoreboard hit (comb.)
//   iss_valid/iss_addr issuing instruction that will write iss_addr
//   iss_full          pending counter of iss_addr saturated, issue must stall
//   flush             clears all pending counters
module gpr_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int PEND_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_full,
  input  logic                     flush
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [PEND_W-1:0] PEND_MAX  = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  logic [DATA_W-1:0] regs     [DEPTH];
  logic [PEND_W-1:0] pend     [DEPTH];
  logic [PEND_W-1:0] pend_nxt [DEPTH];
  logic [ADDR_W-1:0] ra       [NUM_RD];

  logic wr_ok;    // writeback targets a writable register
  logic iss_ok;   // issue targets a writable register
  logic iss_sat;  // issue target counter is saturated
  logic iss_acc;  // issue is accepted into the scoreboard

  // Unpack the read address bus into one address per port.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_unpack
    assign ra[g] = rd_addr[g*ADDR_W +: ADDR_W];
  end

  // Qualify writeback and issue against the hard-wired zero register.
  always_comb begin
    if ((ZERO_REG != 0) && (waddr == ADDR_ZERO)) begin
      wr_ok = 1'b0;
    end else begin
      wr_ok = we;
    end
    if ((ZERO_REG != 0) && (iss_addr == ADDR_ZERO)) begin
      iss_ok = 1'b0;
    end else begin
      iss_ok = iss_valid;
    end
    iss_sat = iss_valid && (pend[iss_addr] == PEND_MAX);
    iss_acc = iss_ok && !iss_sat;
    // Full is deliberately blind to a same-cycle writeback (conservative stall).
    if (rst) begin
      iss_full = 1'b0;
    end else begin
      iss_full = iss_sat;
    end
  end

  // Next value of every pending counter: flush wins, issue+writeback on the
  // same register cancel, otherwise count up on issue or down on writeback.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      pend_nxt[i] = pend[i];
      if (flush) begin
        pend_nxt[i] = PEND_ZERO;
      end else if (iss_acc && (iss_addr == ADDR_W'(i)) &&
                   wr_ok && (waddr == ADDR_W'(i))) begin
        pend_nxt[i] = pend[i];
      end else if (iss_acc && (iss_addr == ADDR_W'(i))) begin
        pend_nxt[i] = pend[i] + PEND_ONE;
      end else if (wr_ok && (waddr == ADDR_W'(i)) && (pend[i] != PEND_ZERO)) begin
        pend_nxt[i] = pend[i] - PEND_ONE;
      end else begin
        pend_nxt[i] = pend[i];
      end
    end
  end

  // Register array and scoreboard state; reset clears both, flush only the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= {DATA_W{1'b0}};
        pend[i] <= PEND_ZERO;
      end
    end else begin
      if (wr_ok) begin
        regs[waddr] <= wdata;
      end
      for (int i = 0; i < DEPTH; i++) begin
        pend[i] <= pend_nxt[i];
      end
    end
  end

  // Read ports with write bypass; busy drops for the final in-flight write
  // because its data is already being forwarded this cycle.
  always_comb begin
    rd_data = {(NUM_RD*DATA_W){1'b0}};
    rd_busy = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      if (rst || !rd_en[k] || ((ZERO_REG != 0) && (ra[k] == ADDR_ZERO))) begin
        rd_data[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
        rd_busy[k]                  = 1'b0;
      end else begin
        if (wr_ok && (waddr == ra[k])) begin
          rd_data[k*DATA_W +: DATA_W] = wdata;
        end else begin
          rd_data[k*DATA_W +: DATA_W] = regs[ra[k]];
        end
        if (pend[ra[k]] == PEND_ZERO) begin
          rd_busy[k] = 1'b0;
        end else if (wr_ok && (waddr == ra[k]) && (pend[ra[k]] == PEND_ONE)) begin
          rd_busy[k] = 1'b0;
        end else begin
          rd_busy[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpr_file_sb.sv
// tb_gpr_file_sb -- self-checking bench for gpr_file_sb.
// A default-parameter instance is checked every cycle against a behavioural
// model (plain arrays of register values and pending counts); a second
// instance (4 ports, 16x16) covers the parameter sweep with directed values.
module tb_gpr_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int PMAX = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, we, iss_valid, flush, iss_full;
  logic [AW-1:0] waddr, iss_addr;
  logic [DW-1:0] wdata;
  logic [NR-1:0] rd_en, rd_busy;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;

  logic s_we, s_iss_valid, s_flush, s_iss_full;
  logic [3:0] s_waddr, s_iss_addr;
  logic [15:0] s_wdata;
  logic [3:0] s_rd_en, s_rd_busy;
  logic [15:0] s_rd_addr;
  logic [63:0] s_rd_data;

  gpr_file_sb dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_full(iss_full), .flush(flush)
  );

  gpr_file_sb #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1), .PEND_W(2)) dut_sweep (
    .clk(clk), .rst(rst), .we(s_we), .waddr(s_waddr), .wdata(s_wdata),
    .rd_en(s_rd_en), .rd_addr(s_rd_addr), .rd_data(s_rd_data), .rd_busy(s_rd_busy),
    .iss_valid(s_iss_valid), .iss_addr(s_iss_addr), .iss_full(s_iss_full), .flush(s_flush)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] m_regs [32];
  int            m_pend [32];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compare all main-instance outputs against the model, before the edge.
  task automatic settle();
    int a;
    logic [DW-1:0] e_data;
    logic e_busy;
    #1;
    for (int k = 0; k < NR; k++) begin
      a = int'(rd_addr[k*AW +: AW]);
      e_data = '0;
      e_busy = 1'b0;
      if (!rst && rd_en[k] && a != 0) begin
        e_data = (we && int'(waddr) == a) ? wdata : m_regs[a];
        e_busy = (m_pend[a] > 0) && !(we && int'(waddr) == a && m_pend[a] == 1);
      end
      check($sformatf("rd_data%0d", k), 64'(rd_data[k*DW +: DW]), 64'(e_data));
      check($sformatf("rd_busy%0d", k), 64'(rd_busy[k]), 64'(e_busy));
    end
    check("iss_full", 64'(iss_full),
          64'(!rst && iss_valid && m_pend[int'(iss_addr)] == PMAX));
  endtask

  // Clock edge: update the model with the inputs applied this cycle.
  task automatic advance();
    int ia, wa;
    bit acc, wb;
    @(posedge clk);
    ia = int'(iss_addr);
    wa = int'(waddr);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = '0;
        m_pend[i] = 0;
      end
    end else begin
      if (we && wa != 0) m_regs[wa] = wdata;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
      end else begin
        acc = iss_valid && ia != 0 && m_pend[ia] < PMAX;
        wb  = we && wa != 0;
        if (!(acc && wb && ia == wa)) begin
          if (acc) m_pend[ia] = m_pend[ia] + 1;
          if (wb && m_pend[wa] > 0) m_pend[wa] = m_pend[wa] - 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; iss_valid = 1'b0; flush = 1'b0;
    waddr = '0; wdata = '0; iss_addr = '0; rd_en = '0; rd_addr = '0;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_en[k] = 1'b1;
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  initial begin
    idle();
    s_we = 1'b0; s_iss_valid = 1'b0; s_flush = 1'b0; s_waddr = '0;
    s_iss_addr = '0; s_wdata = '0; s_rd_en = '0; s_rd_addr = '0;
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 0;
    end

    // Reset for two cycles, then read every register on both ports.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int a = 1; a < 32; a++) begin
      set_rd(0, a);
      set_rd(1, a);
      tick();
    end

    // Write with same-cycle bypass, then from the array; r0 ignores writes.
    idle();
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; set_rd(0, 5);
    settle();
    check("bypass_r5", 64'(rd_data[DW-1:0]), 64'h0000_0000_DEAD_BEEF);
    advance();
    we = 1'b0;
    settle();
    check("array_r5", 64'(rd_data[DW-1:0]), 64'h0000_0000_DEAD_BEEF);
    advance();
    we = 1'b1; waddr = 5'd0; wdata = 32'h0000_1234; set_rd(0, 0);
    tick();
    we = 1'b0;
    settle();
    check("zero_reg", 64'(rd_data[DW-1:0]), 64'h0);
    advance();

    // Scoreboard chain on r7: three issues saturate, the fourth is dropped.
    idle();
    set_rd(0, 7);
    iss_valid = 1'b1; iss_addr = 5'd7;
    for (int i = 0; i < 3; i++) tick();
    settle();
    check("iss_full_r7", 64'(iss_full), 64'h1);
    advance();
    iss_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      we = 1'b1; waddr = 5'd7; wdata = 32'(100 + i);
      settle();
      check($sformatf("busy_r7_wb%0d", i), 64'(rd_busy[0]), 64'(i < 2));
      advance();
    end
    we = 1'b0;
    tick();

    // Issue and writeback of r9 in the same cycle keep the counter at 1.
    idle();
    iss_valid = 1'b1; iss_addr = 5'd9;
    tick();
    we = 1'b1; waddr = 5'd9; wdata = 32'h0000_0909;
    tick();
    idle();
    set_rd(0, 9);
    settle();
    check("busy_r9_hold", 64'(rd_busy[0]), 64'h1);
    advance();

    // Flush mid-operation retains data; reset mid-operation clears it.
    idle();
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0033; tick();
    waddr = 5'd4; wdata = 32'h0000_0044; tick();
    we = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd3; tick(); tick();
    iss_addr = 5'd4; tick();
    iss_valid = 1'b0; flush = 1'b1; tick();
    flush = 1'b0; set_rd(0, 3); set_rd(1, 4);
    settle();
    check("flush_busy", 64'(rd_busy), 64'h0);
    check("flush_r3", 64'(rd_data[DW-1:0]), 64'h33);
    check("flush_r4", 64'(rd_data[2*DW-1:DW]), 64'h44);
    advance();
    iss_valid = 1'b1; iss_addr = 5'd3; tick();
    iss_valid = 1'b0; rst = 1'b1; tick();
    rst = 1'b0;
    settle();
    check("rst_busy", 64'(rd_busy), 64'h0);
    check("rst_r3", 64'(rd_data[DW-1:0]), 64'h0);
    check("rst_r4", 64'(rd_data[2*DW-1:DW]), 64'h0);
    advance();

    // Randomised traffic over a small address window to force collisions.
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      flush     = ($urandom_range(0, 31) == 0);
      we        = $urandom_range(0, 1) == 1;
      waddr     = AW'($urandom_range(0, 7));
      wdata     = $urandom;
      iss_valid = $urandom_range(0, 1) == 1;
      iss_addr  = AW'($urandom_range(0, 7));
      rd_en     = NR'($urandom_range(0, 3));
      rd_addr[AW-1:0]    = AW'($urandom_range(0, 7));
      rd_addr[2*AW-1:AW] = AW'($urandom_range(0, 7));
      tick();
    end

    // Parameter sweep: four ports all reading the register being written.
    idle();
    s_iss_valid = 1'b1; s_iss_addr = 4'd6;
    tick();
    tick();
    s_iss_valid = 1'b0;
    s_we = 1'b1; s_waddr = 4'd6; s_wdata = 16'hA5C3;
    s_rd_en = 4'b1111; s_rd_addr = {4{4'd6}};
    settle();
    for (int k = 0; k < 4; k++)
      check($sformatf("sweep_byp%0d", k), 64'(s_rd_data[k*16 +: 16]), 64'hA5C3);
    check("sweep_busy_p2", 64'(s_rd_busy), 64'hF);
    advance();
    s_wdata = 16'h1111; s_rd_en = 4'b1011;
    settle();
    for (int k = 0; k < 4; k++)
      check($sformatf("sweep_last%0d", k), 64'(s_rd_data[k*16 +: 16]),
            (k == 2) ? 64'h0 : 64'h1111);
    check("sweep_busy_p1", 64'(s_rd_busy), 64'h0);
    advance();
    s_we = 1'b0; s_rd_en = 4'b1111;
    settle();
    for (int k = 0; k < 4; k++)
      check($sformatf("sweep_arr%0d", k), 64'(s_rd_data[k*16 +: 16]), 64'h1111);
    check("sweep_busy_p0", 64'(s_rd_busy), 64'h0);
    advance();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
